// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command stream to AMBA 3 APB master transfers,
// one response per command, with a PREADY timeout against hung slaves
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d, rsp_rdata_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic                  rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
  logic                  timeout_hit;
  // the current wait cycle is the one that brings the count up to the limit; 0 never matches
  assign timeout_hit = (int'(cnt) + 1) == TIMEOUT_CYCLES;
  assign cmd_ready = state == IDLE;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    paddr_d = paddr;
    pwrite_d = pwrite;
    pwdata_d = pwdata;
    psel_d = psel;
    penable_d = penable;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_slverr_d = rsp_slverr;
    rsp_timeout_d = rsp_timeout;
    case (state)
      IDLE: if (cmd_valid) begin
        state_d = SETUP;
        paddr_d = cmd_addr;
        pwrite_d = cmd_write;
        pwdata_d = cmd_wdata;
        psel_d = 1'b1;
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: if (pready || timeout_hit) begin
        state_d = RESP;
        psel_d = 1'b0;
        penable_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = (pready && !pwrite) ? prdata : '0;
        rsp_slverr_d = pready ? pslverr : 1'b1;
        rsp_timeout_d = !pready;
      end else begin
        cnt_d = cnt + CW'(1);
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state <= IDLE;
      cnt <= '0;
      paddr <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      psel <= 1'b0;
      penable <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_slverr <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      paddr <= paddr_d;
      pwrite <= pwrite_d;
      pwdata <= pwdata_d;
      psel <= psel_d;
      penable <= penable_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_slverr <= rsp_slverr_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized commands and APB slave behaviour checked against
// a per-command response/latency model
module tb_apb_cmd_master;
  localparam int TO = 4;
  logic        pclk, preset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  int total = 0;
  int bad = 0;

  apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic junk_inputs();
    cmd_valid = 1'($urandom);
    cmd_addr = $urandom;
    cmd_write = 1'($urandom);
    cmd_wdata = $urandom;
    pready = 1'($urandom);
    prdata = $urandom;
    pslverr = 1'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // waits = pready-low ACCESS cycles the slave inserts (>= TO means it never answers).
  task automatic do_cmd(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err, input int waits, input int bp);
    bit          to, acc_rdy;
    int          lat;
    logic [31:0] e_rd;
    logic        e_err;
    to = waits >= TO;
    lat = to ? TO + 2 : waits + 3;
    e_rd = (to || w) ? 32'd0 : rd;
    e_err = to ? 1'b1 : err;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_write = w;
    cmd_wdata = wd;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge pclk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge pclk);
      if (k < lat) begin
        chk("psel_busy", 64'(psel), 64'd1);
        chk("penable", 64'(penable), 64'(k > 1));
        chk("paddr", 64'(paddr), 64'(a));
        chk("pwrite", 64'(pwrite), 64'(w));
        chk("pwdata", 64'(pwdata), 64'(wd));
        chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      end else begin
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
        chk("rsp_slverr", 64'(rsp_slverr), 64'(e_err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(to));
        chk("psel_resp", 64'(psel), 64'd0);
        chk("penable_resp", 64'(penable), 64'd0);
        chk("cmd_ready_resp", 64'(cmd_ready), 64'd0);
      end
      junk_inputs();
      if (k > 1 && k < lat) begin
        acc_rdy = !to && k == lat - 1;
        pready = acc_rdy;
        if (acc_rdy) begin
          prdata = rd;
          pslverr = err;
        end
      end
      rsp_ready = (k == lat) ? (bp == 0) : 1'($urandom);
    end
    for (int b = 1; b <= bp; b++) begin
      @(negedge pclk);
      chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_hold_rdata", 64'(rsp_rdata), 64'(e_rd));
      chk("rsp_hold_slverr", 64'(rsp_slverr), 64'(e_err));
      chk("rsp_hold_timeout", 64'(rsp_timeout), 64'(to));
      chk("psel_bp", 64'(psel), 64'd0);
      chk("cmd_ready_bp", 64'(cmd_ready), 64'd0);
      junk_inputs();
      rsp_ready = b == bp;
    end
    @(negedge pclk);
    chk("rsp_valid_done", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_done", 64'(cmd_ready), 64'd1);
    chk("psel_done", 64'(psel), 64'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    pready = 1'($urandom);
  endtask

  initial begin
    cmd_valid = 0; cmd_addr = 0; cmd_write = 0; cmd_wdata = 0;
    rsp_ready = 0; pready = 0; prdata = 0; pslverr = 0;
    preset_n = 1'b1;
    #2 preset_n = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'({rsp_slverr, rsp_timeout}), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    preset_n = 1'b1;
    @(negedge pclk);
    do_cmd(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0);
    do_cmd(32'h0000_0014, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 3, 0);
    do_cmd(32'h0000_0018, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 0);
    do_cmd(32'h0000_001C, 1'b0, 32'h0, 32'h5555_AAAA, 1'b0, TO + 3, 0);
    do_cmd(32'h0000_0020, 1'b1, 32'h0BAD_CAFE, 32'h0, 1'b0, TO - 1, 0);
    do_cmd(32'h0000_0024, 1'b1, 32'h1111_2222, 32'h0, 1'b1, 0, 5);
    do_cmd(32'h0000_0028, 1'b0, 32'h0, 32'h7777_8888, 1'b0, 0, 0);
    // reset asserted while the slave is stalling in ACCESS
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_write = 1'b0; cmd_wdata = 32'h0;
    pready = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    pready = 1'b0;
    @(negedge pclk);
    chk("pre_rst_penable", 64'(penable), 64'd1);
    preset_n = 1'b0;
    #1;
    chk("mid_rst_psel", 64'(psel), 64'd0);
    chk("mid_rst_penable", 64'(penable), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge pclk);
    preset_n = 1'b1;
    rsp_ready = 1'b1;
    pready = 1'b1;
    repeat (4) begin
      @(negedge pclk);
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_psel", 64'(psel), 64'd0);
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    end
    rsp_ready = 1'b0;
    do_cmd(32'h0000_0044, 1'b1, 32'hA5A5_5A5A, 32'h0, 1'b0, 2, 1);
    for (int i = 0; i < 150; i++)
      do_cmd($urandom, 1'($urandom), $urandom, $urandom, 1'($urandom),
             int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
